// File: rtl/sd_img_pkg.sv
// sd_img_pkg: shared state type and sector constants for the SDRAM-backed sector server.
package sd_img_pkg;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned IDX_W        = 9;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECTOR_BYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdMem,
        StRdPush,
        StWrAddr,
        StWrWait,
        StWrMem,
        StDone
    } state_e;

    // Number of sectors an image spans, counting a partial last sector as whole.
    function automatic logic [23:0] sector_count(input logic [31:0] size);
        logic [32:0] sum;
        sum = {1'b0, size} + 33'd511;
        return sum[32:9];
    endfunction

endpackage

// File: rtl/sd_img_server_if.sv
// sd_img_server_if: u765 sector handshake plus the SDRAM byte port, bundled.
interface sd_img_server_if;
    import sd_img_pkg::*;

    logic [31:0]      sd_lba;
    logic             sd_rd;
    logic             sd_wr;
    logic             sd_ack;
    logic [IDX_W-1:0] sd_buff_addr;
    logic [7:0]       sd_buff_dout;
    logic             sd_buff_wr;
    logic [7:0]       sd_buff_din;

    logic [24:0]      mem_addr;
    logic             mem_rd;
    logic             mem_wr;
    logic [7:0]       mem_dout;
    logic [7:0]       mem_din;
    logic             mem_ready;

    // slave: the sector server; master: the requester and SDRAM side.
    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_din, mem_ready,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output mem_addr, mem_rd, mem_wr, mem_dout
    );

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_din, mem_ready,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  mem_addr, mem_rd, mem_wr, mem_dout
    );

endinterface

// File: rtl/sd_img_server.sv
// sd_img_server: serves 512-byte sectors to u765 from a disk image resident in SDRAM.
// Define SDIMG_WRITE_EN to build the write path; otherwise writes are acked and dropped.
module sd_img_server
    import sd_img_pkg::*;
#(
    parameter logic [24:0] IMG_BASE = 25'h0800000,
    parameter int unsigned BUF_LAT  = 2
) (
    input logic            clk_sys_i,
    input logic            reset_i,
    input logic [31:0]     img_size_i,
    sd_img_server_if.slave bus_io
);

    state_e           state_q;
    logic [15:0]      lba_q;
    logic [IDX_W-1:0] idx_q;
    logic             in_range_q;
    logic             ack_q;
    logic [IDX_W-1:0] buff_addr_q;
    logic [7:0]       buff_dout_q;
    logic             buff_wr_q;
    logic [24:0]      mem_addr_q;
    logic             mem_rd_q;

    logic [23:0]      n_sectors;
    logic             req_in_range;
    logic [24:0]      cur_addr;

    assign n_sectors    = sector_count(img_size_i);
    assign req_in_range = bus_io.sd_lba < {8'd0, n_sectors};
    // Only lba[15:0] reaches the address; the sum wraps at 25 bits.
    assign cur_addr     = IMG_BASE + {lba_q, idx_q};

`ifdef SDIMG_WRITE_EN
    localparam int unsigned WaitW = $clog2(BUF_LAT + 2);

    logic             mem_wr_q;
    logic [7:0]       mem_dout_q;
    logic [WaitW-1:0] wait_q;
`endif

    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            lba_q       <= '0;
            idx_q       <= '0;
            in_range_q  <= 1'b0;
            ack_q       <= 1'b0;
            buff_addr_q <= '0;
            buff_dout_q <= '0;
            buff_wr_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
`ifdef SDIMG_WRITE_EN
            mem_wr_q    <= 1'b0;
            mem_dout_q  <= '0;
            wait_q      <= '0;
`endif
        end else begin
            buff_wr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.sd_rd || bus_io.sd_wr) begin
                        lba_q      <= bus_io.sd_lba[15:0];
                        idx_q      <= '0;
                        in_range_q <= req_in_range;
                        ack_q      <= 1'b1;
                        state_q    <= bus_io.sd_rd ? StRdMem : StWrAddr;
                    end
                end
                StRdMem: begin
                    if (!in_range_q) begin
                        buff_addr_q <= idx_q;
                        buff_dout_q <= 8'hFF;
                        buff_wr_q   <= 1'b1;
                        state_q     <= StRdPush;
                    end else if (!mem_rd_q) begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= cur_addr;
                    end else if (bus_io.mem_ready) begin
                        mem_rd_q    <= 1'b0;
                        buff_addr_q <= idx_q;
                        buff_dout_q <= bus_io.mem_din;
                        buff_wr_q   <= 1'b1;
                        state_q     <= StRdPush;
                    end
                end
                StRdPush: begin
                    if (idx_q == LAST_IDX) begin
                        ack_q   <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StRdMem;
                    end
                end
`ifdef SDIMG_WRITE_EN
                StWrAddr: begin
                    buff_addr_q <= idx_q;
                    wait_q      <= '0;
                    state_q     <= StWrWait;
                end
                StWrWait: begin
                    // Requester RAM needs BUF_LAT cycles after the address moves.
                    if (wait_q == WaitW'(BUF_LAT)) begin
                        mem_dout_q <= bus_io.sd_buff_din;
                        state_q    <= StWrMem;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StWrMem: begin
                    if (in_range_q && !mem_wr_q) begin
                        mem_wr_q   <= 1'b1;
                        mem_addr_q <= cur_addr;
                    end else if (!in_range_q || bus_io.mem_ready) begin
                        mem_wr_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            ack_q   <= 1'b0;
                            state_q <= StDone;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= StWrAddr;
                        end
                    end
                end
`else
                StWrAddr: begin
                    // Write requests only step through the sector; nothing reaches SDRAM.
                    buff_addr_q <= idx_q;
                    if (idx_q == LAST_IDX) begin
                        ack_q   <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
`endif
                StDone: begin
                    ack_q <= 1'b0;
                    if (!bus_io.sd_rd && !bus_io.sd_wr) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.sd_ack       = ack_q;
    assign bus_io.sd_buff_addr = buff_addr_q;
    assign bus_io.sd_buff_dout = buff_dout_q;
    assign bus_io.sd_buff_wr   = buff_wr_q;
    assign bus_io.mem_addr     = mem_addr_q;
    assign bus_io.mem_rd       = mem_rd_q;
`ifdef SDIMG_WRITE_EN
    assign bus_io.mem_wr       = mem_wr_q;
    assign bus_io.mem_dout     = mem_dout_q;
`else
    assign bus_io.mem_wr       = 1'b0;
    assign bus_io.mem_dout     = 8'h00;
`endif

endmodule

// File: doc/sd_img_server.md
Name: sd_img_server

Overview:
- Responder end of the sector-request handshake that u765 drives (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*).
- Serves 512-byte sectors from a disk image already resident in SDRAM (loaded through ioctl), replacing the SPI host path for that drive.
- Sits between u765 and a spare byte port of the SDRAM controller.

Parameters:
- IMG_BASE, 25'h0800000, byte address of image byte 0 in SDRAM.
- BUF_LAT, 2, clk_sys cycles from sd_buff_addr change to valid sd_buff_din (requester buffer RAM latency).

Ports:
- clk_sys in 1: system clock.
- reset in 1: synchronous, active-high.
- img_size in 32: image length in bytes; 0 means no image.
- sd_lba in 32: requested sector; sampled on request acceptance.
- sd_rd in 1: read-sector request, level, held until sd_ack seen.
- sd_wr in 1: write-sector request, level, held until sd_ack seen.
- sd_ack out 1: high for the whole transfer.
- sd_buff_addr out 9: byte index within the sector.
- sd_buff_dout out 8: read data to requester.
- sd_buff_wr out 1: one-cycle strobe, dout valid at addr.
- sd_buff_din in 8: write data from requester.
- mem_addr out 25: SDRAM byte address.
- mem_rd out 1: read request, held until mem_ready.
- mem_wr out 1: write request, held until mem_ready.
- mem_dout out 8: SDRAM write data.
- mem_din in 8: SDRAM read data, valid with mem_ready.
- mem_ready in 1: one-cycle access-complete pulse.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; any pending mem access is abandoned (deassert only, no wait).
- IDLE
  - sd_rd=1 → latch lba, idx=0, in_range = (lba < ceil(img_size/512)); enter RD_MEM.
  - sd_wr=1 (and sd_rd=0) → same latch; enter WR_ADDR.
  - sd_rd and sd_wr both high: read wins.
- sd_ack rises on the cycle after acceptance and stays high through DONE.
- mem_addr = IMG_BASE + {lba[15:0], idx[8:0]}, 25-bit wrap; lba[31:16] ignored for addressing but used in the range check.
- RD_MEM
  - in_range: assert mem_rd until mem_ready, capture mem_din.
  - not in_range: data = 8'hFF immediately, no mem access.
  - Then RD_PUSH.
- RD_PUSH: sd_buff_addr=idx, sd_buff_dout=data, sd_buff_wr=1 for exactly 1 cycle.
  - idx==511 → DONE; else idx+1 and back to RD_MEM.
- WR_ADDR: sd_buff_addr=idx; wait BUF_LAT cycles (WR_WAIT); latch sd_buff_din into mem_dout.
- WR_MEM
  - in_range: assert mem_wr until mem_ready.
  - not in_range: skip the access.
  - idx==511 → DONE; else idx+1 and back to WR_ADDR.
- DONE: drop sd_ack; wait until sd_rd=0 and sd_wr=0 (at least 1 cycle); return to IDLE. No back-to-back accept without the request dropping.
- Requests that change while sd_ack is high are ignored.
- Partial last sector (img_size not a multiple of 512): whole sector is served from memory; bytes past img_size are don't-care.
- img_size=0: every request completes as out-of-range (512×FF on read, writes dropped).
- Minimum read transfer = 512×(mem latency+2)+2 cycles. No timeout.

Optional Feature:
- SDIMG_WRITE_EN
  - Defined: write path as specified.
  - Undefined: WR_ADDR/WR_WAIT/WR_MEM are not built. sd_wr runs a handshake that raises sd_ack, holds it 512 cycles with idx stepping, and drops it. No mem_wr is ever issued and mem_dout is tied to 0.

Decomposition:
- Package sd_img_pkg: FSM state enum (IDLE, RD_MEM, RD_PUSH, WR_ADDR, WR_WAIT, WR_MEM, DONE), SECTOR_BYTES=512, IDX_W=9.
- Single module, no sub-module; the address adder and range compare stay inline.

Test Plan:
- img_size=2048; image bytes = addr[7:0]; sd_lba=2, sd_rd pulse-held
  → 512 sd_buff_wr strobes with addr 0..511, dout = (1024+i)[7:0]; sd_ack drops after idx 511.
- sd_lba=4, img_size=2048, sd_rd
  → 512 strobes all 8'hFF; mem_rd never asserted.
- SDIMG_WRITE_EN; requester buffer = ~i, BUF_LAT=2; sd_lba=1, sd_wr
  → 512 mem_wr at IMG_BASE+512+i with data ~i; a readback of lba 1 returns the same bytes.
- sd_rd and sd_wr raised in the same cycle
  → read transfer only; no mem_wr.
- reset asserted at idx=100 of a read
  → next cycle sd_ack=0, mem_rd=0, sd_buff_wr=0; a new sd_rd then restarts at idx 0.
- mem_ready delayed 7 cycles on every access
  → mem_rd held steady with a stable mem_addr; still exactly 512 strobes, none duplicated.
